// File: rtl/unit_weight_mac_if.sv
// unit_weight_mac_if
//   Bundles the signals between the RAM read driver and the weight MAC block.
//   master modport: the read driver. It drives the weight write strobes, wdata,
//                   sum_trigger and layer_in, and it observes busy, done and
//                   unit_out.
//   slave modport:  unit_weight_mac, which sees the same signals with the
//                   directions reversed.
//   Signals:
//     write, unit_sel[2:0], unit_address[2:0], wdata[DATA_W]
//                   weight load strobe, row/column index and weight word
//     sum_trigger   start-computation pulse
//     layer_in      packed signed inputs; element k is [k*DATA_W +: DATA_W]
//     busy, done    computation in progress / one-cycle completion pulse
//     unit_out      packed signed results; unit u is [u*ACC_W +: ACC_W]
interface unit_weight_mac_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 4,
  parameter int ACC_W     = 18
);
  logic                         write;
  logic [2:0]                   unit_sel;
  logic [2:0]                   unit_address;
  logic [DATA_W-1:0]            wdata;
  logic                         sum_trigger;
  logic [DEPTH*DATA_W-1:0]      layer_in;
  logic                         busy;
  logic                         done;
  logic [NUM_UNITS*ACC_W-1:0]   unit_out;

  modport master (
    output write, unit_sel, unit_address, wdata, sum_trigger, layer_in,
    input  busy, done, unit_out
  );

  modport slave (
    input  write, unit_sel, unit_address, wdata, sum_trigger, layer_in,
    output busy, done, unit_out
  );
endinterface

// File: rtl/unit_weight_mac.sv
// unit_weight_mac
//   Weight bank plus parallel signed MAC for NUM_UNITS neuron units.
//   - Weights are loaded one word at a time while the block is idle.
//   - sum_trigger captures layer_in. Each unit then accumulates one product
//     term per clock for DEPTH clocks.
//   - The results are then loaded into unit_out together with a one-cycle
//     done pulse.
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-low reset
//     bus    unit_weight_mac_if.slave (write/unit_sel/unit_address/wdata,
//            sum_trigger/layer_in in; busy/done/unit_out out)
//   Optional build macro:
//     UNIT_RELU_EN  when defined, negative results are clamped to zero as
//                   they are loaded into unit_out. Accumulation and timing
//                   are the same in both builds.
module unit_weight_mac #(
  parameter int DATA_W    = 8,
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 4,
  parameter int ACC_W     = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  unit_weight_mac_if.slave     bus
);

  localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state;
  logic [KW-1:0]               k;
  logic                        done_q;
  logic [NUM_UNITS*ACC_W-1:0]  out_q;

  logic signed [DATA_W-1:0]    bank [NUM_UNITS][DEPTH];
  logic signed [DATA_W-1:0]    x    [DEPTH];
  logic signed [ACC_W-1:0]     acc  [NUM_UNITS];

  logic signed [2*DATA_W-1:0]  x_ext;
  logic signed [2*DATA_W-1:0]  w_ext [NUM_UNITS];
  logic signed [2*DATA_W-1:0]  prod  [NUM_UNITS];
  logic signed [ACC_W-1:0]     term  [NUM_UNITS];

  function automatic logic signed [ACC_W-1:0] out_map(input logic signed [ACC_W-1:0] v);
`ifdef UNIT_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Operands are widened to the full product width before multiplying, so
  // the product is exact. It is then sign-extended to the accumulator width.
  always_comb begin
    x_ext = (2*DATA_W)'(x[k]);
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      w_ext[u] = (2*DATA_W)'(bank[u][k]);
      prod[u]  = w_ext[u] * x_ext;
      term[u]  = ACC_W'(prod[u]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      k      <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        acc[u] <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) bank[u][d] <= '0;
      end
      for (int unsigned d = 0; d < DEPTH; d++) x[d] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // Out-of-range indices match no entry, so those writes fall away.
          // A write on the trigger edge is visible to the computation,
          // because the first term is read one edge later.
          if (bus.write) begin
            for (int unsigned u = 0; u < NUM_UNITS; u++)
              for (int unsigned d = 0; d < DEPTH; d++)
                if (bus.unit_sel == 3'(u) && bus.unit_address == 3'(d))
                  bank[u][d] <= bus.wdata;
          end
          if (bus.sum_trigger) begin
            for (int unsigned d = 0; d < DEPTH; d++)
              x[d] <= bus.layer_in[d*DATA_W +: DATA_W];
            for (int unsigned u = 0; u < NUM_UNITS; u++) acc[u] <= '0;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          for (int unsigned u = 0; u < NUM_UNITS; u++) acc[u] <= acc[u] + term[u];
          k <= k + 1'b1;
          if (k == KW'(DEPTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          for (int unsigned u = 0; u < NUM_UNITS; u++)
            out_q[u*ACC_W +: ACC_W] <= out_map(acc[u]);
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.unit_out = out_q;

endmodule
